// File: rtl/vx_afu_ctrl_regs.sv
// AXI4-Lite control slave for the Vortex AFU: kernel start/done handshake, interrupt
// controller and a bank of 64-bit scalar argument registers.
module vx_afu_ctrl_regs #(
  parameter int unsigned C_S_AXI_CTRL_ADDR_WIDTH = 8,
  parameter int unsigned C_S_AXI_CTRL_DATA_WIDTH = 32,
  parameter int unsigned NUM_SCALARS             = 4,
  parameter bit          AUTO_RESTART_EN         = 1'b1
) (
  input  logic                                 ap_clk,
  input  logic                                 reset,
  input  logic                                 s_axi_ctrl_awvalid,
  output logic                                 s_axi_ctrl_awready,
  input  logic [C_S_AXI_CTRL_ADDR_WIDTH-1:0]   s_axi_ctrl_awaddr,
  input  logic                                 s_axi_ctrl_wvalid,
  output logic                                 s_axi_ctrl_wready,
  input  logic [C_S_AXI_CTRL_DATA_WIDTH-1:0]   s_axi_ctrl_wdata,
  input  logic [C_S_AXI_CTRL_DATA_WIDTH/8-1:0] s_axi_ctrl_wstrb,
  output logic                                 s_axi_ctrl_bvalid,
  input  logic                                 s_axi_ctrl_bready,
  output logic [1:0]                           s_axi_ctrl_bresp,
  input  logic                                 s_axi_ctrl_arvalid,
  output logic                                 s_axi_ctrl_arready,
  input  logic [C_S_AXI_CTRL_ADDR_WIDTH-1:0]   s_axi_ctrl_araddr,
  output logic                                 s_axi_ctrl_rvalid,
  input  logic                                 s_axi_ctrl_rready,
  output logic [C_S_AXI_CTRL_DATA_WIDTH-1:0]   s_axi_ctrl_rdata,
  output logic [1:0]                           s_axi_ctrl_rresp,
  input  logic [63:0]                          dev_caps,
  output logic                                 ap_start,
  input  logic                                 ap_ready,
  input  logic                                 ap_done,
  input  logic                                 ap_idle,
  output logic [64*NUM_SCALARS-1:0]            scalars,
  output logic                                 interrupt
);

  localparam int unsigned AW = C_S_AXI_CTRL_ADDR_WIDTH;

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  wstate_e       wstate_q;
  rstate_e       rstate_q;
  logic [AW-1:2] waddr_q;
  logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]   rdata_q, rd_mux;

  logic        ap_start_q, ap_start_d, done_q, done_d, ready_q, ready_d;
  logic        auto_restart_q, auto_restart_d, gie_q, gie_d, irq_q, irq_d;
  logic [1:0]  ier_q, ier_d, isr_q, isr_d;
  logic [63:0] scalar_q [NUM_SCALARS];
  logic [63:0] scalar_d [NUM_SCALARS];

  logic        w_fire, ar_fire, wr_ctrl, wr_gie, wr_ier, wr_isr, ar_ctrl;
  logic [31:0] widx, ridx;
  logic        unused_addr_bits;

  assign w_fire  = wready_q & s_axi_ctrl_wvalid;
  assign ar_fire = arready_q & s_axi_ctrl_arvalid;
  assign widx    = 32'(waddr_q);
  assign ridx    = 32'(s_axi_ctrl_araddr[AW-1:2]);
  assign unused_addr_bits = ^{s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0]};

  assign wr_ctrl = w_fire && s_axi_ctrl_wstrb[0] && (widx == 32'd0);
  assign wr_gie  = w_fire && s_axi_ctrl_wstrb[0] && (widx == 32'd1);
  assign wr_ier  = w_fire && s_axi_ctrl_wstrb[0] && (widx == 32'd2);
  assign wr_isr  = w_fire && s_axi_ctrl_wstrb[0] && (widx == 32'd3);
  assign ar_ctrl = ar_fire && (ridx == 32'd0);

  always_comb begin
    ap_start_d = ap_start_q;
    if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;
    if (wr_ctrl && s_axi_ctrl_wdata[0]) ap_start_d = 1'b1;
    // A status pulse coincident with the read-clear wins so no event is lost.
    done_d         = (done_q & ~ar_ctrl) | ap_done;
    ready_d        = (ready_q & ~ar_ctrl) | ap_ready;
    auto_restart_d = wr_ctrl ? (AUTO_RESTART_EN & s_axi_ctrl_wdata[7]) : auto_restart_q;
    gie_d          = wr_gie ? s_axi_ctrl_wdata[0] : gie_q;
    ier_d          = wr_ier ? s_axi_ctrl_wdata[1:0] : ier_q;
    isr_d          = (ier_q & {ap_ready, ap_done}) |
                     (isr_q ^ (wr_isr ? s_axi_ctrl_wdata[1:0] : 2'b00));
    irq_d          = gie_q & |(isr_q & ier_q);
    for (int unsigned k = 0; k < NUM_SCALARS; k++) begin
      scalar_d[k] = scalar_q[k];
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_fire && s_axi_ctrl_wstrb[b]) begin
          if (widx == 32'd8 + 2 * k) scalar_d[k][8*b +: 8] = s_axi_ctrl_wdata[8*b +: 8];
          if (widx == 32'd9 + 2 * k) scalar_d[k][32+8*b +: 8] = s_axi_ctrl_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ridx)
      32'd0: rd_mux = {24'b0, auto_restart_q, 3'b0, ready_q, ap_idle, done_q, ap_start_q};
      32'd1: rd_mux = {31'b0, gie_q};
      32'd2: rd_mux = {30'b0, ier_q};
      32'd3: rd_mux = {30'b0, isr_q};
      32'd4: rd_mux = dev_caps[31:0];
      32'd5: rd_mux = dev_caps[63:32];
      default: begin
        for (int unsigned k = 0; k < NUM_SCALARS; k++) begin
          if (ridx == 32'd8 + 2 * k) rd_mux = scalar_q[k][31:0];
          if (ridx == 32'd9 + 2 * k) rd_mux = scalar_q[k][63:32];
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (reset) begin
      ap_start_q     <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      auto_restart_q <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= 2'b00;
      isr_q          <= 2'b00;
      irq_q          <= 1'b0;
      for (int unsigned k = 0; k < NUM_SCALARS; k++) scalar_q[k] <= '0;
    end else begin
      ap_start_q     <= ap_start_d;
      done_q         <= done_d;
      ready_q        <= ready_d;
      auto_restart_q <= auto_restart_d;
      gie_q          <= gie_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      irq_q          <= irq_d;
      for (int unsigned k = 0; k < NUM_SCALARS; k++) scalar_q[k] <= scalar_d[k];
    end
  end

  // Write channel: ready flags are registered so they stay low through reset.
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      wstate_q  <= WIdle;
      waddr_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (wstate_q)
        WIdle: begin
          if (awready_q && s_axi_ctrl_awvalid) begin
            waddr_q   <= s_axi_ctrl_awaddr[AW-1:2];
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= WData;
          end else begin
            awready_q <= 1'b1;
          end
        end
        WData: begin
          if (s_axi_ctrl_wvalid) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            wstate_q <= WResp;
          end
        end
        WResp: begin
          if (s_axi_ctrl_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= WIdle;
          end
        end
        default: wstate_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (reset) begin
      rstate_q  <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (rstate_q)
        RIdle: begin
          if (ar_fire) begin
            rdata_q   <= rd_mux;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rstate_q  <= RData;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RData: begin
          if (s_axi_ctrl_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= RIdle;
          end
        end
        default: rstate_q <= RIdle;
      endcase
    end
  end

  always_comb begin
    scalars = '0;
    for (int unsigned k = 0; k < NUM_SCALARS; k++) scalars[64*k +: 64] = scalar_q[k];
  end

  assign s_axi_ctrl_awready = awready_q;
  assign s_axi_ctrl_wready  = wready_q;
  assign s_axi_ctrl_bvalid  = bvalid_q;
  assign s_axi_ctrl_bresp   = 2'b00;
  assign s_axi_ctrl_arready = arready_q;
  assign s_axi_ctrl_rvalid  = rvalid_q;
  assign s_axi_ctrl_rdata   = rdata_q;
  assign s_axi_ctrl_rresp   = 2'b00;
  assign ap_start           = ap_start_q;
  assign interrupt          = irq_q;

endmodule

// File: tb/tb_vx_afu_ctrl_regs.sv
// Directed bench for vx_afu_ctrl_regs: AXI-Lite register accesses with hand-computed
// expectations for the control handshake, interrupts and scalar bank.
module tb_vx_afu_ctrl_regs;

  logic        ap_clk = 1'b0;
  logic        reset;
  logic        s_axi_ctrl_awvalid, s_axi_ctrl_awready;
  logic [7:0]  s_axi_ctrl_awaddr;
  logic        s_axi_ctrl_wvalid, s_axi_ctrl_wready;
  logic [31:0] s_axi_ctrl_wdata;
  logic [3:0]  s_axi_ctrl_wstrb;
  logic        s_axi_ctrl_bvalid, s_axi_ctrl_bready;
  logic [1:0]  s_axi_ctrl_bresp;
  logic        s_axi_ctrl_arvalid, s_axi_ctrl_arready;
  logic [7:0]  s_axi_ctrl_araddr;
  logic        s_axi_ctrl_rvalid, s_axi_ctrl_rready;
  logic [31:0] s_axi_ctrl_rdata;
  logic [1:0]  s_axi_ctrl_rresp;
  logic [63:0] dev_caps;
  logic        ap_start, ap_ready, ap_done, ap_idle;
  logic [255:0] scalars;
  logic        interrupt;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  vx_afu_ctrl_regs #(
    .C_S_AXI_CTRL_ADDR_WIDTH(8),
    .C_S_AXI_CTRL_DATA_WIDTH(32),
    .NUM_SCALARS(4),
    .AUTO_RESTART_EN(1'b1)
  ) dut (
    .ap_clk(ap_clk), .reset(reset),
    .s_axi_ctrl_awvalid(s_axi_ctrl_awvalid), .s_axi_ctrl_awready(s_axi_ctrl_awready),
    .s_axi_ctrl_awaddr(s_axi_ctrl_awaddr),
    .s_axi_ctrl_wvalid(s_axi_ctrl_wvalid), .s_axi_ctrl_wready(s_axi_ctrl_wready),
    .s_axi_ctrl_wdata(s_axi_ctrl_wdata), .s_axi_ctrl_wstrb(s_axi_ctrl_wstrb),
    .s_axi_ctrl_bvalid(s_axi_ctrl_bvalid), .s_axi_ctrl_bready(s_axi_ctrl_bready),
    .s_axi_ctrl_bresp(s_axi_ctrl_bresp),
    .s_axi_ctrl_arvalid(s_axi_ctrl_arvalid), .s_axi_ctrl_arready(s_axi_ctrl_arready),
    .s_axi_ctrl_araddr(s_axi_ctrl_araddr),
    .s_axi_ctrl_rvalid(s_axi_ctrl_rvalid), .s_axi_ctrl_rready(s_axi_ctrl_rready),
    .s_axi_ctrl_rdata(s_axi_ctrl_rdata), .s_axi_ctrl_rresp(s_axi_ctrl_rresp),
    .dev_caps(dev_caps), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_idle(ap_idle), .scalars(scalars), .interrupt(interrupt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic axi_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int g;
    s_axi_ctrl_awaddr  = addr;
    s_axi_ctrl_awvalid = 1'b1;
    g = 0;
    while (!s_axi_ctrl_awready && g < 20) begin tick(); g++; end
    if (!s_axi_ctrl_awready) check("aw_timeout", {63'b0, s_axi_ctrl_awready}, 64'd1);
    tick();
    s_axi_ctrl_awvalid = 1'b0;
    s_axi_ctrl_wdata   = data;
    s_axi_ctrl_wstrb   = strb;
    s_axi_ctrl_wvalid  = 1'b1;
    g = 0;
    while (!s_axi_ctrl_wready && g < 20) begin tick(); g++; end
    if (!s_axi_ctrl_wready) check("w_timeout", {63'b0, s_axi_ctrl_wready}, 64'd1);
    tick();
    s_axi_ctrl_wvalid = 1'b0;
    s_axi_ctrl_bready = 1'b1;
    g = 0;
    while (!s_axi_ctrl_bvalid && g < 20) begin tick(); g++; end
    if (!s_axi_ctrl_bvalid) check("b_timeout", {63'b0, s_axi_ctrl_bvalid}, 64'd1);
    tick();
    s_axi_ctrl_bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [7:0] addr, output logic [31:0] data);
    int g;
    s_axi_ctrl_araddr  = addr;
    s_axi_ctrl_arvalid = 1'b1;
    g = 0;
    while (!s_axi_ctrl_arready && g < 20) begin tick(); g++; end
    if (!s_axi_ctrl_arready) check("ar_timeout", {63'b0, s_axi_ctrl_arready}, 64'd1);
    tick();
    s_axi_ctrl_arvalid = 1'b0;
    check("rd_latency", {63'b0, s_axi_ctrl_rvalid}, 64'd1);
    g = 0;
    while (!s_axi_ctrl_rvalid && g < 20) begin tick(); g++; end
    data = s_axi_ctrl_rdata;
    s_axi_ctrl_rready = 1'b1;
    tick();
    s_axi_ctrl_rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(addr, d);
    check(tag, {32'b0, d}, {32'b0, exp});
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s_axi_ctrl_awvalid = 1'b0; s_axi_ctrl_awaddr = '0;
    s_axi_ctrl_wvalid  = 1'b0; s_axi_ctrl_wdata  = '0; s_axi_ctrl_wstrb = '0;
    s_axi_ctrl_bready  = 1'b0;
    s_axi_ctrl_arvalid = 1'b0; s_axi_ctrl_araddr = '0;
    s_axi_ctrl_rready  = 1'b0;
    dev_caps = 64'h0123_4567_89AB_CDEF;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_awready", {63'b0, s_axi_ctrl_awready}, 64'd0);
    check("rst_arready", {63'b0, s_axi_ctrl_arready}, 64'd0);
    check("rst_bvalid", {63'b0, s_axi_ctrl_bvalid}, 64'd0);
    check("rst_rvalid", {63'b0, s_axi_ctrl_rvalid}, 64'd0);
    check("rst_rdata", {32'b0, s_axi_ctrl_rdata}, 64'd0);
    check("rst_start", {63'b0, ap_start}, 64'd0);
    check("rst_irq", {63'b0, interrupt}, 64'd0);
    check("rst_scalars", scalars[63:0] | scalars[255:192], 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_awready", {63'b0, s_axi_ctrl_awready}, 64'd1);
    check("post_rst_arready", {63'b0, s_axi_ctrl_arready}, 64'd1);
    rd_chk("ctrl_idle", 8'h00, 32'h0000_0004);

    // Start handshake without and with auto-restart
    axi_wr(8'h00, 32'h1, 4'hF);
    check("start_set", {63'b0, ap_start}, 64'd1);
    pulse_ready();
    check("start_clr", {63'b0, ap_start}, 64'd0);
    rd_chk("ctrl_ready", 8'h00, 32'h0000_000C);
    rd_chk("ctrl_ready_cleared", 8'h00, 32'h0000_0004);
    axi_wr(8'h00, 32'h81, 4'hF);
    pulse_ready();
    check("start_autorestart", {63'b0, ap_start}, 64'd1);
    rd_chk("ctrl_auto", 8'h00, 32'h0000_008D);
    axi_wr(8'h00, 32'h0, 4'hF);
    check("start_w0_noeffect", {63'b0, ap_start}, 64'd1);
    pulse_ready();
    check("start_clr2", {63'b0, ap_start}, 64'd0);
    rd_chk("ctrl_after_auto_off", 8'h00, 32'h0000_000C);

    // Interrupts
    axi_wr(8'h08, 32'h1, 4'h1);
    axi_wr(8'h04, 32'h1, 4'h1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("irq_not_yet", {63'b0, interrupt}, 64'd0);
    tick();
    check("irq_set", {63'b0, interrupt}, 64'd1);
    rd_chk("isr_done", 8'h0C, 32'h1);
    rd_chk("ctrl_done", 8'h00, 32'h0000_0006);
    rd_chk("ctrl_done_cleared", 8'h00, 32'h0000_0004);
    axi_wr(8'h0C, 32'h1, 4'h1);
    check("irq_cleared", {63'b0, interrupt}, 64'd0);
    rd_chk("isr_cleared", 8'h0C, 32'h0);
    axi_wr(8'h0C, 32'h2, 4'h1);
    rd_chk("isr_toggle_ready", 8'h0C, 32'h2);
    check("irq_masked", {63'b0, interrupt}, 64'd0);
    axi_wr(8'h0C, 32'h2, 4'h1);
    rd_chk("isr_toggle_back", 8'h0C, 32'h0);
    rd_chk("ier_rd", 8'h08, 32'h1);

    // Scalars, capabilities, unmapped space
    axi_wr(8'h30, 32'h1122_3344, 4'hF);
    axi_wr(8'h30, 32'hAABB_CCDD, 4'b0101);
    check("s2lo_strb", {32'b0, scalars[159:128]}, 64'h11BB_33DD);
    rd_chk("s2lo_rd", 8'h30, 32'h11BB_33DD);
    axi_wr(8'h34, 32'hAABB_CCDD, 4'b0101);
    rd_chk("s2hi_partial", 8'h34, 32'h00BB_00DD);
    axi_wr(8'h34, 32'hAABB_CCDD, 4'hF);
    rd_chk("s2hi_full", 8'h34, 32'hAABB_CCDD);
    check("s2hi_port", {32'b0, scalars[191:160]}, 64'hAABB_CCDD);
    axi_wr(8'h20, 32'hCAFE_F00D, 4'hF);
    check("s0lo_port", scalars[63:0], 64'h0000_0000_CAFE_F00D);
    axi_wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped_40", 8'h40, 32'h0);
    rd_chk("unmapped_18", 8'h18, 32'h0);
    rd_chk("s3hi_untouched", 8'h3C, 32'h0);
    rd_chk("caps_lo", 8'h10, 32'h89AB_CDEF);
    rd_chk("caps_hi", 8'h14, 32'h0123_4567);

    // Write held in WRESP with bready low, read running concurrently
    s_axi_ctrl_awaddr = 8'h38; s_axi_ctrl_awvalid = 1'b1;
    s_axi_ctrl_wdata = 32'h5; s_axi_ctrl_wstrb = 4'hF; s_axi_ctrl_wvalid = 1'b1;
    tick();
    tick();
    s_axi_ctrl_wdata = 32'h7;
    check("hold_bvalid_first", {63'b0, s_axi_ctrl_bvalid}, 64'd1);
    rd_chk("hold_concurrent_rd", 8'h38, 32'h5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_bvalid", {63'b0, s_axi_ctrl_bvalid}, 64'd1);
      check("hold_awready", {63'b0, s_axi_ctrl_awready}, 64'd0);
    end
    check("hold_single_commit", {32'b0, scalars[223:192]}, 64'h5);
    s_axi_ctrl_awvalid = 1'b0; s_axi_ctrl_wvalid = 1'b0; s_axi_ctrl_bready = 1'b1;
    tick();
    s_axi_ctrl_bready = 1'b0;
    check("hold_released", {63'b0, s_axi_ctrl_bvalid}, 64'd0);

    // ap_done coincident with the AR handshake on AP_CTRL
    s_axi_ctrl_araddr = 8'h00; s_axi_ctrl_arvalid = 1'b1; ap_done = 1'b1;
    tick();
    s_axi_ctrl_arvalid = 1'b0; ap_done = 1'b0;
    check("race_rvalid", {63'b0, s_axi_ctrl_rvalid}, 64'd1);
    check("race_old_value", {32'b0, s_axi_ctrl_rdata}, 64'h4);
    s_axi_ctrl_rready = 1'b1;
    tick();
    s_axi_ctrl_rready = 1'b0;
    rd_chk("race_done_kept", 8'h00, 32'h0000_0006);

    // Reset while the write sits in WDATA
    check("pre_rst_s0", scalars[63:0], 64'h0000_0000_CAFE_F00D);
    s_axi_ctrl_awaddr = 8'h20; s_axi_ctrl_awvalid = 1'b1;
    tick();
    s_axi_ctrl_awvalid = 1'b0;
    check("pre_rst_wready", {63'b0, s_axi_ctrl_wready}, 64'd1);
    s_axi_ctrl_wdata = 32'hFFFF_FFFF; s_axi_ctrl_wstrb = 4'hF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_axi_ctrl_wvalid = 1'b1;
    check("midrst_bvalid", {63'b0, s_axi_ctrl_bvalid}, 64'd0);
    check("midrst_wready", {63'b0, s_axi_ctrl_wready}, 64'd0);
    check("midrst_irq", {63'b0, interrupt}, 64'd0);
    tick();
    tick();
    check("midrst_no_resp", {63'b0, s_axi_ctrl_bvalid}, 64'd0);
    check("midrst_no_commit", scalars[63:0], 64'd0);
    s_axi_ctrl_wvalid = 1'b0;
    rd_chk("midrst_ctrl", 8'h00, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
